alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Sequencer and arbiter that shares the single combinational 8-bit ALU between two requesters (for example, an instruction datapath and an address/loop unit).
- Accepts one operation at a time through a valid/ready handshake, using round-robin arbitration between the two requesters.
- Drives the ALU operands and alucont from registered state, captures the result and zero flag, and returns them to the winning requester.
- Validates op codes before any ALU use.

Parameters:
- W, 8, operand and result width; must match the ALU width.
- RST_GRANT, 1, initial value of the last-granted pointer. With the default, requester 0 wins the first tie.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  4  requester 0 alucont code.
- req0_a  in  W  requester 0 operand A.
- req0_b  in  W  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp0_valid  out  1  one-cycle pulse: result for requester 0.
- rsp1_valid  out  1  one-cycle pulse: result for requester 1.
- rsp_data  out  W  result; shared by both requesters.
- rsp_zero  out  1  rsp_data equals 0.
- rsp_err  out  1  the operation had an illegal op code.
- alu_reg_1  out  W  ALU operand A.
- alu_reg_2  out  W  ALU operand B.
- alu_cont  out  4  ALU function select.
- alu_out  in  W  ALU result.
- alu_zero  in  1  ALU zero flag.

Behaviour:
- Legal ops: 0000 AND, 0001 OR, 0010 ADD, 0101 XOR, 0110 SUB, 0111 SLT. All other codes are illegal, except 0011 when the optional feature is compiled in.
- States and transitions:
  - IDLE -> EXEC on accept of a legal op.
  - IDLE -> RESP on accept of an illegal op.
  - EXEC -> RESP after one cycle, or after MUL completes.
  - RESP -> IDLE after one cycle.
- Ready: reqN_ready is high only in IDLE, and only for the granted requester. Accept = reqN_valid && reqN_ready.
- Round-robin arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - The pointer updates only on accept.
- On accept, register op, a, b and the winner ID.
- EXEC: drive alu_reg_1=a, alu_reg_2=b, alu_cont=op. Capture alu_out and alu_zero at the end of the cycle.
- RESP: assert rspN_valid for exactly one cycle. rsp_data and rsp_zero hold the captured values.
- Latency:
  - Accept in cycle t gives rsp valid in cycle t+2.
  - Next accept is possible no earlier than t+3.
  - Throughput is one op per 3 cycles.
- Illegal op:
  - The ALU is not driven with it; alu_cont is held at 0000.
  - In RESP: rsp_err=1, rsp_data=0, rsp_zero=1, latency t+1.
- Responses are not back-pressured; requesters must sample on the pulse.
- Outside EXEC: alu_reg_1=0, alu_reg_2=0, alu_cont=0000.
- Reset values: all outputs 0, state IDLE, pointer=RST_GRANT.
- Reset mid-operation: the in-flight op is dropped and no response is issued.
- Valid deasserted before accept: no effect on state.
- Operands and op are sampled only at accept; changes after accept are ignored.
- Arithmetic wraps modulo 2^W.

Optional Feature:
- Macro: ALU_ARB_MUL_EN.
- Defined: op 0011 = MUL, giving the low W bits of a*b.
  - Implemented as shift-add through the ALU: acc=0; for i=0..W-1, if b[i]=1, acc = ALU ADD(acc, (a<<i) truncated to W).
  - Uses alu_cont=0010 and stays in the MUL state for W cycles.
  - rsp_zero comes from the final acc.
  - rsp valid at cycle t+W+1.
- Undefined: 0011 is illegal (rsp_err path). No MUL state or shifter is synthesized.

Decomposition:
- Package alu_arb_pkg contains:
  - op localparams: OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT, OP_MUL;
  - state enum: IDLE, EXEC, MUL, RESP;
  - a legality function.
- One sub-module, rr_arb2: two-way round-robin grant with the pointer register.

Test Plan:
- req0 ADD a=0x7F b=0x01 -> rsp0_valid at t+2, rsp_data=0x80, zero=0, err=0.
- req1 SUB a=0x05 b=0x05 -> rsp1_valid, rsp_data=0x00, rsp_zero=1.
- Both valid continuously after reset -> grants alternate 0,1,0,1; ready is never high during EXEC or RESP.
- req0 op=0100 -> rsp0_valid at t+1 with err=1, data=0; alu_cont stays 0000 throughout.
- rst_n low during EXEC of an XOR from req1 -> no rsp1_valid; all outputs 0 the next cycle; next accept goes to req0.
- With ALU_ARB_MUL_EN: MUL a=0x0D b=0x0B -> rsp_data=0x8F at t+9. Without the macro: the same stimulus gives err=1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arb_pkg
//  Purpose  : Op codes, sequencer state encoding and op legality for alu_arbiter.
//             ALU_ARB_MUL_EN makes op 0011 (MUL) legal.
//  Revision : 1.0  initial release
// ============================================================================
package alu_arb_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] MUL  = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   function automatic logic op_is_legal(input logic [3:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT: op_is_legal = 1'b1;
`ifdef ALU_ARB_MUL_EN
         OP_MUL:                                        op_is_legal = 1'b1;
`endif
         default:                                       op_is_legal = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin grant; the last-granted pointer moves on accept.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 #(
   parameter bit RST_GRANT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic r_last;

   // On a tie the requester that did not win last time goes first.
   always_comb begin
      grant = 2'b00;
      if (en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last <= RST_GRANT;
      end else if (accept) begin
         r_last <= grant[1];
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one combinational ALU between two requesters with a
//             round-robin valid/ready front end. ALU_ARB_MUL_EN adds shift-add MUL.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int W         = 8,
   parameter bit RST_GRANT = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [3:0]   req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [3:0]   req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         rsp0_valid,
   output logic         rsp1_valid,
   output logic [W-1:0] rsp_data,
   output logic         rsp_zero,
   output logic         rsp_err,
   output logic [W-1:0] alu_reg_1,
   output logic [W-1:0] alu_reg_2,
   output logic [3:0]   alu_cont,
   input  logic [W-1:0] alu_out,
   input  logic         alu_zero
);

   logic [1:0]   r_state;
   logic [3:0]   r_op;
   logic [W-1:0] r_a;
   logic [W-1:0] r_b;
   logic         r_id;
   logic [W-1:0] r_data;
   logic         r_zero;
   logic         r_err;

`ifdef ALU_ARB_MUL_EN
   localparam int c_CNT_W = $clog2(W);
   logic [c_CNT_W-1:0] r_cnt;
`endif

   logic         w_en;
   logic [1:0]   w_grant;
   logic         w_acc0;
   logic         w_acc1;
   logic         w_accept;
   logic [3:0]   w_sel_op;
   logic [W-1:0] w_sel_a;
   logic [W-1:0] w_sel_b;
   logic         w_legal;
   logic         w_resp;

   // Ready is withheld while reset is asserted so nothing is accepted then.
   assign w_en = rst_n && (r_state == IDLE);

   rr_arb2 #(
      .RST_GRANT (RST_GRANT)
   ) u_rr_arb2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (w_en),
      .req    ({req1_valid, req0_valid}),
      .accept (w_accept),
      .grant  (w_grant)
   );

   assign req0_ready = w_grant[0];
   assign req1_ready = w_grant[1];
   assign w_acc0     = req0_valid && req0_ready;
   assign w_acc1     = req1_valid && req1_ready;
   assign w_accept   = w_acc0 || w_acc1;

   assign w_sel_op = w_acc1 ? req1_op : req0_op;
   assign w_sel_a  = w_acc1 ? req1_a  : req0_a;
   assign w_sel_b  = w_acc1 ? req1_b  : req0_b;
   assign w_legal  = op_is_legal(w_sel_op);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_op    <= 4'b0000;
         r_a     <= '0;
         r_b     <= '0;
         r_id    <= 1'b0;
         r_data  <= '0;
         r_zero  <= 1'b0;
         r_err   <= 1'b0;
`ifdef ALU_ARB_MUL_EN
         r_cnt   <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op <= w_sel_op;
                  r_a  <= w_sel_a;
                  r_b  <= w_sel_b;
                  r_id <= w_acc1;
                  // Illegal ops skip the ALU and carry a fixed zero result.
                  if (w_legal) begin
                     r_data <= '0;
                     r_zero <= 1'b0;
                     r_err  <= 1'b0;
`ifdef ALU_ARB_MUL_EN
                     r_cnt   <= '0;
                     r_state <= (w_sel_op == OP_MUL) ? MUL : EXEC;
`else
                     r_state <= EXEC;
`endif
                  end else begin
                     r_data  <= '0;
                     r_zero  <= 1'b1;
                     r_err   <= 1'b1;
                     r_state <= RESP;
                  end
               end
            end
            EXEC: begin
               r_data  <= alu_out;
               r_zero  <= alu_zero;
               r_state <= RESP;
            end
`ifdef ALU_ARB_MUL_EN
            MUL: begin
               // r_data is the accumulator; r_a/r_b walk the shifted partial products.
               r_data <= alu_out;
               r_zero <= alu_zero;
               r_a    <= r_a << 1;
               r_b    <= r_b >> 1;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == c_CNT_W'(W - 1)) begin
                  r_state <= RESP;
               end
            end
`endif
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      alu_reg_1 = '0;
      alu_reg_2 = '0;
      alu_cont  = 4'b0000;
      case (r_state)
         EXEC: begin
            alu_reg_1 = r_a;
            alu_reg_2 = r_b;
            alu_cont  = r_op;
         end
`ifdef ALU_ARB_MUL_EN
         MUL: begin
            alu_reg_1 = r_data;
            alu_reg_2 = r_b[0] ? r_a : '0;
            alu_cont  = OP_ADD;
         end
`endif
         default: begin
            alu_cont = 4'b0000;
         end
      endcase
   end

   assign w_resp     = (r_state == RESP);
   assign rsp0_valid = w_resp && !r_id;
   assign rsp1_valid = w_resp &&  r_id;
   assign rsp_data   = w_resp ? r_data : '0;
   assign rsp_zero   = w_resp && r_zero;
   assign rsp_err    = w_resp && r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Directed and random stimulus for alu_arbiter against a
//             transaction-level reference model; honours ALU_ARB_MUL_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

   localparam int W         = 8;
   localparam bit RST_GRANT = 1'b1;
`ifdef ALU_ARB_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [3:0]   req0_op = '0, req1_op = '0;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         rsp0_valid, rsp1_valid, rsp_zero, rsp_err;
   logic [W-1:0] rsp_data;
   logic [W-1:0] alu_reg_1, alu_reg_2, alu_out;
   logic [3:0]   alu_cont;
   logic         alu_zero;

   always #5 clk = ~clk;

   alu_arbiter #(.W(W), .RST_GRANT(RST_GRANT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_reg_1(alu_reg_1), .alu_reg_2(alu_reg_2), .alu_cont(alu_cont),
      .alu_out(alu_out), .alu_zero(alu_zero)
   );

   // The shared combinational ALU the arbiter drives.
   always_comb begin
      case (alu_cont)
         4'b0000: alu_out = alu_reg_1 & alu_reg_2;
         4'b0001: alu_out = alu_reg_1 | alu_reg_2;
         4'b0010: alu_out = alu_reg_1 + alu_reg_2;
         4'b0101: alu_out = alu_reg_1 ^ alu_reg_2;
         4'b0110: alu_out = alu_reg_1 - alu_reg_2;
         4'b0111: alu_out = ($signed(alu_reg_1) < $signed(alu_reg_2)) ? W'(1) : '0;
         default: alu_out = '0;
      endcase
   end
   assign alu_zero = (alu_out == '0);

   typedef struct {
      int           due;
      bit           id;
      logic [W-1:0] data;
      bit           zero;
      bit           err;
   } rsp_t;

   rsp_t         exp_q[$];
   int           n_vec = 0, n_err = 0;
   int           cyc = 0, busy_until = 0;
   int           exec_cyc = -1, mul_lo = -1, mul_hi = -2;
   bit           last = RST_GRANT;
   bit           post_rst = 1'b0;
   logic [W-1:0] exec_a, exec_b;
   logic [3:0]   exec_op;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit legal(input logic [3:0] op);
      return (op inside {4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7}) || (MUL_ON && op == 4'h3);
   endfunction

   function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = a * b;
      case (op)
         4'h0:    return a & b;
         4'h1:    return a | b;
         4'h2:    return a + b;
         4'h3:    return p[W-1:0];
         4'h5:    return a ^ b;
         4'h6:    return a - b;
         4'h7:    return ($signed(a) < $signed(b)) ? W'(1) : '0;
         default: return '0;
      endcase
   endfunction

   function automatic logic [3:0] rand_op();
      logic [3:0] ops [7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7};
      if ($urandom_range(0, 3) == 0) return 4'($urandom);
      return ops[$urandom_range(0, 6)];
   endfunction

   // One clock: drive after the edge, check at the falling edge, update the model.
   task automatic step(input bit rst,
                       input bit v0, input logic [3:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input bit v1, input logic [3:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1);
      bit           idle, win, e0, e1, hit, hit_id;
      int           lat;
      logic [3:0]   op;
      logic [W-1:0] a, b;
      rsp_t         r;
      @(posedge clk);
      #1;
      rst_n = !rst;
      req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
      @(negedge clk);
      if (rst) begin
         exp_q.delete();
         busy_until = cyc + 1;
         exec_cyc = -1; mul_lo = -1; mul_hi = -2;
         last = RST_GRANT;
         post_rst = 1'b1;
      end else begin
         idle = (cyc >= busy_until);
         win  = (v0 && v1) ? !last : v1;
         e0   = idle && v0 && !win;
         e1   = idle && v1 && win;
         check("req0_ready", 32'(req0_ready), 32'(e0));
         check("req1_ready", 32'(req1_ready), 32'(e1));

         hit    = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         hit_id = hit ? exp_q[0].id : 1'b0;
         check("rsp0_valid", 32'(rsp0_valid), 32'(hit && !hit_id));
         check("rsp1_valid", 32'(rsp1_valid), 32'(hit && hit_id));
         if (hit) begin
            r = exp_q.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(r.data));
            check("rsp_zero", 32'(rsp_zero), 32'(r.zero));
            check("rsp_err",  32'(rsp_err),  32'(r.err));
         end
         if (post_rst) begin
            check("rst_rsp_data", 32'(rsp_data), 32'h0);
            check("rst_rsp_zero", 32'(rsp_zero), 32'h0);
            check("rst_rsp_err",  32'(rsp_err),  32'h0);
            post_rst = 1'b0;
         end

         if (cyc == exec_cyc) begin
            check("alu_reg_1", 32'(alu_reg_1), 32'(exec_a));
            check("alu_reg_2", 32'(alu_reg_2), 32'(exec_b));
            check("alu_cont",  32'(alu_cont),  32'(exec_op));
         end else if (cyc >= mul_lo && cyc <= mul_hi) begin
            check("alu_cont_mul", 32'(alu_cont), 32'h2);
         end else begin
            check("alu_reg_1_idle", 32'(alu_reg_1), 32'h0);
            check("alu_reg_2_idle", 32'(alu_reg_2), 32'h0);
            check("alu_cont_idle",  32'(alu_cont),  32'h0);
         end

         if (e0 || e1) begin
            op = win ? op1 : op0;
            a  = win ? a1  : a0;
            b  = win ? b1  : b0;
            r.id = win;
            if (legal(op)) begin
               lat    = (op == 4'h3) ? W + 1 : 2;
               r.data = ref_result(op, a, b);
               r.zero = (r.data == '0);
               r.err  = 1'b0;
               if (op == 4'h3) begin
                  mul_lo = cyc + 1; mul_hi = cyc + W;
               end else begin
                  exec_cyc = cyc + 1; exec_a = a; exec_b = b; exec_op = op;
               end
            end else begin
               lat = 1; r.data = '0; r.zero = 1'b1; r.err = 1'b1;
            end
            r.due = cyc + lat;
            exp_q.push_back(r);
            busy_until = cyc + lat + 1;
            last = win;
         end
      end
      cyc++;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      step(1, 0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
      step(1, 0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
      idle_n(2);

      step(0, 1, 4'h2, 8'h7F, 8'h01, 0, 4'h0, '0, '0);
      idle_n(3);
      step(0, 0, 4'h0, '0, '0, 1, 4'h6, 8'h05, 8'h05);
      idle_n(3);

      // Both requesters held valid straight out of reset.
      step(1, 0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
      for (int i = 0; i < 12; i++)
         step(0, 1, 4'h2, W'(i), 8'h10, 1, 4'h5, 8'hA5, W'(i));
      idle_n(3);

      step(0, 1, 4'h4, 8'h12, 8'h34, 0, 4'h0, '0, '0);
      idle_n(3);

      // Reset while req1's XOR is in EXEC.
      step(0, 0, 4'h0, '0, '0, 1, 4'h5, 8'h3C, 8'h0F);
      step(1, 0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
      idle_n(1);
      step(0, 1, 4'h1, 8'h01, 8'h02, 1, 4'h1, 8'h04, 8'h08);
      idle_n(3);

      step(0, 1, 4'h3, 8'h0D, 8'h0B, 0, 4'h0, '0, '0);
      idle_n(W + 3);

      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 2) != 0), rand_op(), W'($urandom), W'($urandom),
              ($urandom_range(0, 2) != 0), rand_op(), W'($urandom), W'($urandom));
      end
      idle_n(W + 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
